// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline package: fetch FSM encoding and common instruction constants.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DROP = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch front end: owns the fetch PC, handshakes with imem,
// buffers stalled words and discards wrong-path fetches after a redirect.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = if_fetch_unit_pkg::RESET_PC,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_valid
);

  fetch_state_t state, state_next;
  logic [31:0]  fetch_pc, target_pc, hold_pc, hold_instr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (redirect_valid)         state_next = imem_ready ? RUN : DROP;
        else if (imem_ready && stall) state_next = HOLD;
      end
      DROP: if (imem_ready) state_next = RUN;
      HOLD: if (redirect_valid || !stall) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      target_pc  <= RESET_PC;
      hold_pc    <= 32'h0;
      hold_instr <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (redirect_valid) begin
            if (imem_ready) fetch_pc  <= redirect_pc;
            else            target_pc <= redirect_pc;
          end else if (imem_ready) begin
            fetch_pc <= fetch_pc + PC_STEP;
            if (stall) begin
              hold_pc    <= fetch_pc;
              hold_instr <= imem_rdata;
            end
          end
        end
        DROP: begin
          // Last redirect wins, including one arriving with the dropped response.
          if (redirect_valid) target_pc <= redirect_pc;
          if (imem_ready)     fetch_pc  <= redirect_valid ? redirect_pc : target_pc;
        end
        HOLD: if (redirect_valid) fetch_pc <= redirect_pc;
        default: ;
      endcase
    end
  end

  always_comb begin
    imem_req       = 1'b0;
    imem_addr      = fetch_pc;
    if_valid       = 1'b0;
    if_pc          = fetch_pc;
    if_instruction = NOP_INSTR;
    if (reset) begin
      if_pc = RESET_PC;
    end else begin
      case (state)
        RUN: begin
          imem_req       = 1'b1;
          if_valid       = imem_ready && !redirect_valid;
          if_instruction = (imem_ready && !redirect_valid) ? imem_rdata : NOP_INSTR;
        end
        DROP: begin
          imem_req = 1'b1;
          if_pc    = target_pc;
        end
        HOLD: begin
          if_pc          = hold_pc;
          if_valid       = !redirect_valid;
          if_instruction = redirect_valid ? NOP_INSTR : hold_instr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit against a simple addressed memory.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        if_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory returns a word derived from the requested address.
  assign imem_rdata = imem_addr ^ 32'hDEAD_BEEF;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .if_valid       (if_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic stl, input logic rv, input logic [31:0] rpc);
    imem_ready     = rdy;
    stall          = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic chk_run(input string tag, input logic [31:0] a);
    chk({tag, "_req"},   {31'b0, imem_req}, 32'd1);
    chk({tag, "_addr"},  imem_addr, a);
    chk({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
    chk({tag, "_pc"},    if_pc, a);
    chk({tag, "_instr"}, if_instruction, word(a));
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_req",   {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_pc",    if_pc, 32'h8000_0000);
    chk("rst_instr", if_instruction, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0);

    chk_run("seq0", 32'h8000_0000);
    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk_run("seq1", 32'h8000_0004);
    tick(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk_run("seq2_stall", 32'h8000_0008);

    for (int i = 0; i < 2; i++) begin
      tick(); drive(1'b1, 1'b1, 1'b0, 32'h0);
      chk("hold_req",   {31'b0, imem_req}, 32'd0);
      chk("hold_valid", {31'b0, if_valid}, 32'd1);
      chk("hold_pc",    if_pc, 32'h8000_0008);
      chk("hold_instr", if_instruction, word(32'h8000_0008));
    end
    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("hold_release_valid", {31'b0, if_valid}, 32'd1);
    chk("hold_release_pc",    if_pc, 32'h8000_0008);
    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk_run("resume", 32'h8000_000C);

    tick(); drive(1'b0, 1'b0, 1'b1, 32'h8000_0100);
    chk("wait_redir_addr",  imem_addr, 32'h8000_0010);
    chk("wait_redir_valid", {31'b0, if_valid}, 32'd0);
    chk("wait_redir_instr", if_instruction, 32'h0);
    tick(); drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("drop_req",   {31'b0, imem_req}, 32'd1);
    chk("drop_addr",  imem_addr, 32'h8000_0010);
    chk("drop_valid", {31'b0, if_valid}, 32'd0);
    chk("drop_pc",    if_pc, 32'h8000_0100);
    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("drop_ready_valid", {31'b0, if_valid}, 32'd0);
    chk("drop_ready_instr", if_instruction, 32'h0);
    tick(); drive(1'b0, 1'b0, 1'b1, 32'h8000_0180);
    chk("redir_target_addr", imem_addr, 32'h8000_0100);

    tick(); drive(1'b0, 1'b0, 1'b1, 32'h8000_0200);
    chk("drop2_addr", imem_addr, 32'h8000_0100);
    tick(); drive(1'b1, 1'b0, 1'b1, 32'h8000_0300);
    chk("drop2_pc",    if_pc, 32'h8000_0200);
    chk("drop2_valid", {31'b0, if_valid}, 32'd0);
    tick(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk_run("last_redir", 32'h8000_0300);

    tick(); drive(1'b1, 1'b1, 1'b1, 32'h8000_0400);
    chk("hold_redir_req",   {31'b0, imem_req}, 32'd0);
    chk("hold_redir_valid", {31'b0, if_valid}, 32'd0);
    chk("hold_redir_instr", if_instruction, 32'h0);
    tick(); drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("after_hold_redir_addr", imem_addr, 32'h8000_0400);
    chk("redir_ready_valid", {31'b0, if_valid}, 32'd0);

    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk_run("wrap_top", 32'hFFFF_FFFC);
    tick(); drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr",  imem_addr, 32'h0000_0000);
    chk("wrap_wait_valid", {31'b0, if_valid}, 32'd0);

    tick();
    reset = 1'b1;
    #1;
    chk("midreset_req",   {31'b0, imem_req}, 32'd0);
    chk("midreset_valid", {31'b0, if_valid}, 32'd0);
    chk("midreset_pc",    if_pc, 32'h8000_0000);
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk_run("restart", 32'h8000_0000);
    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk_run("restart1", 32'h8000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end of the 5-stage MIPS pipeline.
- Owns the fetch PC and drives requests to instruction memory with a req/ready handshake.
- Delivers {if_pc, if_instruction, if_valid} to the IF/ID pipeline register, the producer side of that interface.
- Honours the IF/ID stall (buffers a fetched word the register could not take) and redirects from branch/jump/exception logic, discarding wrong-path fetches.

Parameters:
- RESET_PC, 32'h80000000, fetch address after reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- stall  input  1  IF/ID register holds this cycle; fetched word not consumed.
- redirect_valid  input  1  flush wrong path, fetch from redirect_pc.
- redirect_pc  input  32  redirect target.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  input  1  memory returns imem_rdata this cycle; zero or more wait cycles.
- imem_rdata  input  32  fetched instruction word.
- if_pc  output  32  address of the presented instruction.
- if_instruction  output  32  presented instruction; 32'b0 (NOP) when if_valid=0.
- if_valid  output  1  if_instruction is a real, correct-path instruction.

Behaviour:
- Registers:
  - fetch_pc: address of the current/next request.
  - target_pc: pending redirect target.
  - hold_pc, hold_instr: buffered word.
  - state: RUN, DROP or HOLD.
- Reset (asynchronous):
  - state=RUN, fetch_pc=RESET_PC, target_pc=RESET_PC, hold_pc=0, hold_instr=0.
  - While reset is high: imem_req=0, if_valid=0, if_instruction=0, if_pc=RESET_PC.
- Outputs are combinational from state and registers. In RUN, if_instruction passes imem_rdata through to the IF/ID register in the same cycle, giving zero added latency.
- RUN:
  - imem_req=1, imem_addr=fetch_pc.
  - if_valid=imem_ready & ~redirect_valid; if_pc=fetch_pc; if_instruction=imem_rdata when valid, else 0.
  - redirect_valid=1 and imem_ready=1: discard the word, fetch_pc<=redirect_pc, stay RUN.
  - redirect_valid=1 and imem_ready=0: target_pc<=redirect_pc, go DROP.
  - imem_ready=1 and stall=0: fetch_pc<=fetch_pc+PC_STEP, stay RUN. This gives 1 instr/cycle with a zero-wait memory.
  - imem_ready=1 and stall=1: hold_pc<=fetch_pc, hold_instr<=imem_rdata, fetch_pc<=fetch_pc+PC_STEP, go HOLD.
  - imem_ready=0: no state change; stall ignored.
- DROP (the outstanding wrong-path request must complete):
  - imem_req=1, imem_addr=fetch_pc (unchanged); if_valid=0, if_instruction=0, if_pc=target_pc.
  - A further redirect_valid overwrites target_pc (last redirect wins).
  - imem_ready=1: discard the word, fetch_pc<=(redirect_valid ? redirect_pc : target_pc), go RUN.
- HOLD:
  - imem_req=0; if_valid=1, if_pc=hold_pc, if_instruction=hold_instr.
  - redirect_valid=1 takes priority over stall: if_valid=0, if_instruction=0; fetch_pc<=redirect_pc, go RUN.
  - Otherwise stall=0: the word is consumed this cycle, go RUN (fetch resumes at the already-advanced fetch_pc next cycle).
  - Otherwise stall=1: remain in HOLD.
- Simultaneous events: redirect beats stall and beats imem_ready in every state. A word is never presented valid in the same cycle as redirect_valid.
- Arithmetic: 32-bit PC add with modulo wrap (32'hFFFFFFFC+4 -> 0). No alignment check.
- Reset mid-request: the outstanding response is ignored (imem_req drops); after reset, fetch restarts at RESET_PC.

Decomposition:
- Shared pipeline package:
  - state encoding (RUN=2'd0, DROP=2'd1, HOLD=2'd2);
  - constants RESET_PC and NOP_INSTR=32'b0, also used by the IF/ID register and hazard unit.
- No sub-module: the PC incrementer and hold buffer are inline; the block stays one module.

Test Plan:
- Reset release with ready tied 1, stall=0 -> imem_addr 80000000, 80000004, 80000008 on consecutive cycles, if_valid=1 each cycle.
- Ready=1, stall=1 for 3 cycles at 80000008 -> HOLD, imem_req=0, if_pc=80000008 held with the same word; after stall drops, next request at 8000000C.
- Ready=0 for 2 cycles at 80000010, redirect to 80000100 in first wait cycle -> DROP, if_valid=0; old word discarded on ready; next request 80000100.
- Two redirects during DROP (80000200, then 80000300) -> next fetch 80000300.
- redirect_valid with stall=1 in HOLD -> if_valid=0 and instruction 0 that cycle; next request at the redirect target.
- fetch_pc=FFFFFFFC, ready=1 -> next imem_addr 00000000; assert reset mid-wait -> imem_req=0 immediately; restart at 80000000.
